// File: rtl/i8255_pkg.sv
// ---------------------------------------------------------------------------
// i8255_pkg
// Shared definitions for the i8255 bus master: sequencer state encoding,
// 8255 register addresses, the control-word reset value and the width of the
// per-phase timing counter.
// ---------------------------------------------------------------------------
package i8255_pkg;

  // Width of the single phase down-counter; covers timing values 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_PA   = 2'd0;
  localparam logic [1:0] ADDR_PB   = 2'd1;
  localparam logic [1:0] ADDR_PC   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Control word the 8255 holds after its own reset: mode 0, all ports input.
  localparam logic [7:0] CTRL_RESET_WORD = 8'h9B;

endpackage

// File: rtl/i8255_bus_master_if.sv
// ---------------------------------------------------------------------------
// i8255_bus_master_if
// Groups the two-client request/response channel and the 8255 host-side bus.
//
// Handshake: a client raises req_valid[i] with req_rw/reqN_addr/reqN_wdata
// stable and keeps them stable until the cycle in which req_ready[i] is also
// high; the request transfers on that rising edge (valid & ready). req_ready
// never depends on a request being withdrawn, and a request is never dropped.
// rsp_valid[i] is a one-cycle pulse with no back-pressure; rsp_rdata is valid
// with it and holds until the next read completes.
//
// Modports:
//   master - the bus master block (drives ready/response and the 8255 bus)
//   slave  - the environment (clients and the 8255 side)
// ---------------------------------------------------------------------------
interface i8255_bus_master_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_rw;
  logic [1:0] req0_addr;
  logic [1:0] req1_addr;
  logic [7:0] req0_wdata;
  logic [7:0] req1_wdata;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_rdata;
  logic       cs;
  logic       rd;
  logic       wr;
  logic [1:0] a;
  logic [7:0] d_o;
  logic       d_oe;
  logic [7:0] d_i;

  modport master (
    input  req_valid, req_rw, req0_addr, req1_addr, req0_wdata, req1_wdata, d_i,
    output req_ready, rsp_valid, rsp_rdata, cs, rd, wr, a, d_o, d_oe
  );

  modport slave (
    output req_valid, req_rw, req0_addr, req1_addr, req0_wdata, req1_wdata, d_i,
    input  req_ready, rsp_valid, rsp_rdata, cs, rd, wr, a, d_o, d_oe
  );
endinterface

// File: rtl/i8255_rr_arb.sv
// ---------------------------------------------------------------------------
// i8255_rr_arb
// Two-way round-robin arbiter. The grant is combinational from req_i and the
// pointer; the pointer moves on an edge where adv_i is high so that the
// client not granted last wins the next tie. After reset client 0 wins.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_i[1:0]  request per client
//   adv_i       a grant was consumed this cycle; update the pointer
//   gnt_o[1:0]  one-hot grant (zero when no request)
//   ptr_o       client favoured on a tie
// ---------------------------------------------------------------------------
module i8255_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  // After granting client 0 favour client 1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (|gnt_o)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/i8255_bus_master.sv
// ---------------------------------------------------------------------------
// i8255_bus_master
// Arbitrates between two internal clients and runs one 8255 bus cycle per
// accepted transaction: SETUP (a/d driven) -> STROBE (cs + rd|wr) -> HOLD
// (a/d held) -> DONE (response pulse). The DONE cycle falls
// SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after the accept edge. All bus
// outputs are registered.
//
// Parameters: SETUP_CYC, STROBE_CYC, HOLD_CYC (1..15 each).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   bus          i8255_bus_master_if.master (client channel + 8255 bus)
//   dbg_state_o  current sequencer state
//   dbg_rr_ptr_o round-robin pointer (client favoured on a tie)
//
// Build option: define I8255_CTRL_SHADOW_EN to keep a shadow of the last
// mode-set control word; reads of the control register are then answered
// from the shadow without a bus cycle. Without it, no shadow exists and
// control reads run a normal bus cycle.
// ---------------------------------------------------------------------------
module i8255_bus_master
  import i8255_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                clk,
  input  logic                reset,
  i8255_bus_master_if.master  bus,
  output state_t              dbg_state_o,
  output logic                dbg_rr_ptr_o
);

  // Counter reload values: each phase lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q;
  logic             rw_q;
  logic             cs_q, rd_q, wr_q, d_oe_q;
  logic [1:0]       a_q;
  logic [7:0]       d_o_q;
  logic [1:0]       rsp_valid_q;
  logic [7:0]       rsp_rdata_q;

  logic [1:0] gnt;
  logic       idle;
  logic       accept;
  logic       gnt_id;
  logic       sel_rw;
  logic [1:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       shadow_rd;
  logic [7:0] shadow_val;

  i8255_rr_arb u_arb (
    .clk   (clk),
    .rst_n (reset),
    .req_i (bus.req_valid),
    .adv_i (accept),
    .gnt_o (gnt),
    .ptr_o (dbg_rr_ptr_o)
  );

  // Ready is only offered out of IDLE and never while reset is held.
  assign idle          = (state_q == ST_IDLE) && reset;
  assign bus.req_ready = idle ? gnt : 2'b00;
  assign accept        = idle && (|gnt);

  assign gnt_id    = gnt[1];
  assign sel_rw    = gnt_id ? bus.req_rw[1]  : bus.req_rw[0];
  assign sel_addr  = gnt_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = gnt_id ? bus.req1_wdata : bus.req0_wdata;

`ifdef I8255_CTRL_SHADOW_EN
  logic [7:0] shadow_q;

  // Only mode-set words (bit 7 = 1) change the port configuration; bit
  // set/reset words leave the shadow alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= CTRL_RESET_WORD;
    end else if (accept && !sel_rw && (sel_addr == ADDR_CTRL) && sel_wdata[7]) begin
      shadow_q <= sel_wdata;
    end
  end

  assign shadow_rd  = sel_rw && (sel_addr == ADDR_CTRL);
  assign shadow_val = shadow_q;
`else
  assign shadow_rd  = 1'b0;
  assign shadow_val = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      rw_q        <= 1'b0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      d_oe_q      <= 1'b0;
      a_q         <= '0;
      d_o_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            id_q <= gnt_id;
            rw_q <= sel_rw;
            if (shadow_rd) begin
              // Control read served locally: straight to the response.
              state_q     <= ST_DONE;
              rsp_valid_q <= {gnt_id, ~gnt_id};
              rsp_rdata_q <= shadow_val;
              d_oe_q      <= 1'b0;
            end else begin
              state_q <= ST_SETUP;
              cnt_q   <= SETUP_LD;
              a_q     <= sel_addr;
              d_oe_q  <= ~sel_rw;
              if (!sel_rw) begin
                d_o_q <= sel_wdata;
              end
            end
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_STROBE;
            cnt_q   <= STROBE_LD;
            cs_q    <= 1'b1;
            rd_q    <= rw_q;
            wr_q    <= ~rw_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LD;
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            // Last strobe edge: the 8255 data has had the full strobe width.
            if (rw_q) begin
              rsp_rdata_q <= bus.d_i;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= {id_q, ~id_q};
            d_oe_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cs        = cs_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_q;
  assign bus.a         = a_q;
  assign bus.d_o       = d_o_q;
  assign bus.d_oe      = d_oe_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_i8255_bus_master.sv
// ---------------------------------------------------------------------------
// tb_i8255_bus_master
// Directed bench for i8255_bus_master. Instance u_a uses default timing
// (1/1/1); instance u_b uses 2/3/1. Both share clock and reset.
// Honours I8255_CTRL_SHADOW_EN for the control-register read step.
// ---------------------------------------------------------------------------
module tb_i8255_bus_master;
  import i8255_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  int     checks = 0;
  int     errors = 0;
  state_t st_a;
  state_t st_b;
  logic   ptr_a;
  logic   ptr_b;

  logic [1:0] exp_q[$];
  logic [1:0] rsp_q[$];
  state_t     st1_exp[5];
  int         lat;
  bit         cs_seen;
  int         grants;
  int         rsp0_cnt;
  int         rsp1_cnt;
  logic [7:0] wd_exp;

  i8255_bus_master_if bus_a();
  i8255_bus_master_if bus_b();

  i8255_bus_master u_a (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_a),
    .dbg_state_o  (st_a),
    .dbg_rr_ptr_o (ptr_a)
  );

  i8255_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)) u_b (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_b),
    .dbg_state_o  (st_b),
    .dbg_rr_ptr_o (ptr_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on u_a; returns cycles from accept to rsp_valid
  // (0 if it never came) and whether cs was seen in between.
  task automatic run_a(input int cl, input logic rw, input logic [1:0] addr,
                       input logic [7:0] wd, output int lat_o, output bit cs_o);
    int n;
    bus_a.req_rw[cl] = rw;
    if (cl == 0) begin
      bus_a.req0_addr  = addr;
      bus_a.req0_wdata = wd;
    end else begin
      bus_a.req1_addr  = addr;
      bus_a.req1_wdata = wd;
    end
    bus_a.req_valid[cl] = 1'b1;
    #1;
    n = 0;
    while (!bus_a.req_ready[cl] && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("accept_wait_c%0d", cl), 32'(n < 10), 1);
    tick();
    bus_a.req_valid[cl] = 1'b0;
    lat_o = 0;
    cs_o  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus_a.cs) cs_o = 1'b1;
      if (bus_a.rsp_valid[cl]) begin
        lat_o = k;
        break;
      end
      tick();
    end
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    st1_exp = '{ST_SETUP, ST_STROBE, ST_HOLD, ST_DONE, ST_IDLE};
    reset = 1'b0;
    bus_a.req_valid = '0; bus_a.req_rw = '0; bus_a.req0_addr = '0; bus_a.req1_addr = '0;
    bus_a.req0_wdata = '0; bus_a.req1_wdata = '0; bus_a.d_i = '0;
    bus_b.req_valid = '0; bus_b.req_rw = '0; bus_b.req0_addr = '0; bus_b.req1_addr = '0;
    bus_b.req0_wdata = '0; bus_b.req1_wdata = '0; bus_b.d_i = '0;

    // Reset values
    tick();
    chk("rst_state_a", st_a, ST_IDLE);
    chk("rst_state_b", st_b, ST_IDLE);
    chk("rst_cs", bus_a.cs, 0);
    chk("rst_rd", bus_a.rd, 0);
    chk("rst_wr", bus_a.wr, 0);
    chk("rst_d_oe", bus_a.d_oe, 0);
    chk("rst_a", bus_a.a, 0);
    chk("rst_d_o", bus_a.d_o, 0);
    chk("rst_rsp_valid", bus_a.rsp_valid, 0);
    chk("rst_rsp_rdata", bus_a.rsp_rdata, 0);
    chk("rst_ptr_a", ptr_a, 0);
    chk("rst_ptr_b", ptr_b, 0);
    bus_a.req_valid = 2'b11;
    #1;
    chk("rst_ready_gated", bus_a.req_ready, 2'b00);
    bus_a.req_valid = 2'b00;
    #1 reset = 1'b1;
    tick();

    // Write PA, client 0, 0xA5, default timing
    bus_a.req_rw[0] = 1'b0; bus_a.req0_addr = ADDR_PA; bus_a.req0_wdata = 8'hA5;
    bus_a.req_valid = 2'b01;
    #1;
    chk("wr_ready", bus_a.req_ready, 2'b01);
    tick();
    bus_a.req_valid = 2'b00;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("wr_state_c%0d", c), st_a, st1_exp[c-1]);
      chk($sformatf("wr_a_c%0d", c), bus_a.a, 0);
      chk($sformatf("wr_d_o_c%0d", c), bus_a.d_o, 8'hA5);
      chk($sformatf("wr_d_oe_c%0d", c), bus_a.d_oe, 32'(c <= 3));
      chk($sformatf("wr_cs_c%0d", c), bus_a.cs, 32'(c == 2));
      chk($sformatf("wr_wr_c%0d", c), bus_a.wr, 32'(c == 2));
      chk($sformatf("wr_rd_c%0d", c), bus_a.rd, 0);
      chk($sformatf("wr_rsp_c%0d", c), bus_a.rsp_valid, (c == 4) ? 2'b01 : 2'b00);
      tick();
    end

    // Read PB, client 1, d_i = 0x3C, timing 2/3/1
    bus_b.d_i = 8'h3C; bus_b.req_rw = 2'b10; bus_b.req1_addr = ADDR_PB;
    bus_b.req_valid = 2'b10;
    #1;
    chk("rd_ready", bus_b.req_ready, 2'b10);
    tick();
    bus_b.req_valid = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      if (c == 6) bus_b.d_i = 8'hFF;
      if (c == 1) chk("rd_state_setup", st_b, ST_SETUP);
      chk($sformatf("rd_cs_c%0d", c), bus_b.cs, 32'(c >= 3 && c <= 5));
      chk($sformatf("rd_rd_c%0d", c), bus_b.rd, 32'(c >= 3 && c <= 5));
      chk($sformatf("rd_wr_c%0d", c), bus_b.wr, 0);
      chk($sformatf("rd_d_oe_c%0d", c), bus_b.d_oe, 0);
      chk($sformatf("rd_a_c%0d", c), bus_b.a, 1);
      chk($sformatf("rd_rsp_c%0d", c), bus_b.rsp_valid, (c == 7) ? 2'b10 : 2'b00);
      if (c >= 7) chk($sformatf("rd_rdata_c%0d", c), bus_b.rsp_rdata, 8'h3C);
      tick();
    end

    // Reset during STROBE
    bus_a.req_rw[0] = 1'b0; bus_a.req0_addr = ADDR_PC; bus_a.req0_wdata = 8'h77;
    bus_a.req_valid = 2'b01;
    #1;
    chk("mid_ready", bus_a.req_ready, 2'b01);
    tick();
    bus_a.req_valid = 2'b00;
    tick();
    chk("mid_cs_before", bus_a.cs, 1);
    chk("mid_wr_before", bus_a.wr, 1);
    chk("mid_ptr_before", ptr_a, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_cs_async", bus_a.cs, 0);
    chk("mid_wr_async", bus_a.wr, 0);
    chk("mid_d_oe_async", bus_a.d_oe, 0);
    chk("mid_state_async", st_a, ST_IDLE);
    chk("mid_ptr_async", ptr_a, 0);
    tick();
    chk("mid_rsp_in_reset1", bus_a.rsp_valid, 0);
    tick();
    chk("mid_rsp_in_reset2", bus_a.rsp_valid, 0);
    #2 reset = 1'b1;
    tick();
    chk("mid_rsp_after", bus_a.rsp_valid, 0);

    // Both clients valid continuously: grants alternate starting at client 0
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    rsp_q.delete();
    grants = 0; rsp0_cnt = 0; rsp1_cnt = 0; wd_exp = 8'h00;
    bus_a.req_rw = 2'b00;
    bus_a.req0_addr = ADDR_PC; bus_a.req0_wdata = 8'h5A;
    bus_a.req1_addr = ADDR_PB; bus_a.req1_wdata = 8'hC3;
    bus_a.req_valid = 2'b11;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (|bus_a.rsp_valid) begin
        if (rsp_q.size() > 0) chk("rr_rsp_owner", bus_a.rsp_valid, rsp_q.pop_front());
        else chk("rr_rsp_extra", bus_a.rsp_valid, 2'b00);
        rsp0_cnt += int'(bus_a.rsp_valid[0]);
        rsp1_cnt += int'(bus_a.rsp_valid[1]);
      end
      if (bus_a.cs && bus_a.wr) chk("rr_d_o", bus_a.d_o, wd_exp);
      if (|bus_a.req_ready) begin
        if (exp_q.size() > 0) chk("rr_grant", bus_a.req_ready, exp_q.pop_front());
        else chk("rr_grant_extra", bus_a.req_ready, 2'b00);
        rsp_q.push_back(bus_a.req_ready);
        wd_exp = bus_a.req_ready[0] ? 8'h5A : 8'hC3;
        grants++;
      end
      tick();
      if (grants >= 4) bus_a.req_valid = 2'b00;
      if (grants >= 4 && rsp_q.size() == 0 && st_a == ST_IDLE) break;
    end
    chk("rr_grants", grants, 4);
    chk("rr_rsp0_count", rsp0_cnt, 2);
    chk("rr_rsp1_count", rsp1_cnt, 2);
    chk("rr_rsp_pending", rsp_q.size(), 0);

    // Control register: mode word, bit set/reset word, then read back
    bus_a.d_i = 8'h55;
    run_a(0, 1'b0, ADDR_CTRL, 8'h80, lat, cs_seen);
    chk("ctrl_wr1_lat", lat, 4);
    chk("ctrl_wr1_cs", cs_seen, 1);
    run_a(0, 1'b0, ADDR_CTRL, 8'h0E, lat, cs_seen);
    chk("ctrl_wr2_lat", lat, 4);
    run_a(0, 1'b1, ADDR_CTRL, 8'h00, lat, cs_seen);
`ifdef I8255_CTRL_SHADOW_EN
    chk("ctrl_rd_lat", lat, 1);
    chk("ctrl_rd_cs", cs_seen, 0);
    chk("ctrl_rd_data", bus_a.rsp_rdata, 8'h80);
`else
    chk("ctrl_rd_lat", lat, 4);
    chk("ctrl_rd_cs", cs_seen, 1);
    chk("ctrl_rd_data", bus_a.rsp_rdata, 8'h55);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
